// File: rtl/fir_bram_ctrl_if.sv
// Bus bundle between the FIR batch sequencer and its surroundings.
// The signals group into the top-level command/status pair, the input BRAM
// read port, the FIR filter port and the output BRAM write port.
//   i_start, i_length, i_rd_base, i_wr_base : batch command
//   o_busy, o_done                          : batch status
//   o_rd_en, o_rd_addr, i_rd_data           : input BRAM read port
//   o_fir_reset, o_fir_en, o_fir_signal,
//   i_fir_signal                            : FIR filter port
//   o_wr_en, o_wr_addr, o_wr_data           : output BRAM write port
// The master modport is the sequencer; the slave modport is everything around it.
interface fir_bram_ctrl_if #(
    parameter int WW_ADDR = 10,
    parameter int WW_DATA = 8
);
    logic               i_start;
    logic [WW_ADDR-1:0] i_length;
    logic [WW_ADDR-1:0] i_rd_base;
    logic [WW_ADDR-1:0] i_wr_base;
    logic               o_busy;
    logic               o_done;
    logic               o_rd_en;
    logic [WW_ADDR-1:0] o_rd_addr;
    logic [WW_DATA-1:0] i_rd_data;
    logic               o_fir_reset;
    logic               o_fir_en;
    logic [WW_DATA-1:0] o_fir_signal;
    logic [WW_DATA-1:0] i_fir_signal;
    logic               o_wr_en;
    logic [WW_ADDR-1:0] o_wr_addr;
    logic [WW_DATA-1:0] o_wr_data;

    modport master (
        input  i_start, i_length, i_rd_base, i_wr_base, i_rd_data, i_fir_signal,
        output o_busy, o_done, o_rd_en, o_rd_addr, o_fir_reset, o_fir_en,
               o_fir_signal, o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        output i_start, i_length, i_rd_base, i_wr_base, i_rd_data, i_fir_signal,
        input  o_busy, o_done, o_rd_en, o_rd_addr, o_fir_reset, o_fir_en,
               o_fir_signal, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/fir_bram_ctrl.sv
// Batch sequencer for the BRAM-backed FIR datapath.
// On start it clears the FIR history for one cycle, streams i_length samples
// from the input BRAM region into the FIR one per clock, and writes each
// filtered result to the output BRAM region. Read data and FIR results are
// aligned by two enable shift chains (BRAM read latency, FIR latency).
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous active-high reset (also forces the FIR clear)
//   bus     : fir_bram_ctrl_if master modport (command, status, BRAM and FIR ports)
module fir_bram_ctrl #(
    parameter int WW_ADDR     = 10,
    parameter int WW_DATA     = 8,
    parameter int RD_LATENCY  = 1,
    parameter int FIR_LATENCY = 3
) (
    input  logic            i_clock,
    input  logic            i_reset,
    fir_bram_ctrl_if.master bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [WW_ADDR-1:0] ADDR_ZERO = {WW_ADDR{1'b0}};
    localparam logic [WW_ADDR-1:0] ADDR_ONE  = {{(WW_ADDR-1){1'b0}}, 1'b1};

    logic [2:0]             state_r;
    logic [2:0]             state_s;
    logic [WW_ADDR-1:0]     len_r;
    logic [WW_ADDR-1:0]     rd_base_r;
    logic [WW_ADDR-1:0]     wr_base_r;
    logic [WW_ADDR-1:0]     rd_cnt_r;
    logic [WW_ADDR-1:0]     wr_cnt_r;
    logic [WW_ADDR-1:0]     rd_addr_r;
    logic                   rd_en_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   clear_r;
    logic [RD_LATENCY-1:0]  rd_pipe_r;
    logic [FIR_LATENCY-1:0] wr_pipe_r;
    logic [WW_ADDR-1:0]     len_m1_s;
    logic                   last_rd_s;
    logic                   last_wr_s;
    logic                   fir_en_s;
    logic                   wr_en_s;

    assign fir_en_s  = rd_pipe_r[RD_LATENCY-1];
    assign wr_en_s   = wr_pipe_r[FIR_LATENCY-1];
    assign len_m1_s  = len_r - ADDR_ONE;
    assign last_rd_s = (rd_cnt_r == len_m1_s);
    assign last_wr_s = wr_en_s && (wr_cnt_r == len_m1_s);

    // Next-state decode for the batch FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    // A zero-length batch skips the FIR clear and all transfers.
                    state_s = (bus.i_length == ADDR_ZERO) ? ST_DONE : ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: state_s = ST_READ;
            ST_READ: begin
                if (last_rd_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (last_wr_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, status flags, read address generation and enable pipelines.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            len_r     <= ADDR_ZERO;
            rd_base_r <= ADDR_ZERO;
            wr_base_r <= ADDR_ZERO;
            rd_cnt_r  <= ADDR_ZERO;
            wr_cnt_r  <= ADDR_ZERO;
            rd_addr_r <= ADDR_ZERO;
            rd_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            clear_r   <= 1'b0;
            rd_pipe_r <= {RD_LATENCY{1'b0}};
            wr_pipe_r <= {FIR_LATENCY{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            clear_r <= (state_s == ST_CLEAR);

            // Read-valid chain: o_rd_en delayed by the BRAM read latency.
            rd_pipe_r[0] <= rd_en_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe_r[i] <= rd_pipe_r[i-1];
            end
            // Write-valid chain: FIR input enable delayed by the FIR latency.
            wr_pipe_r[0] <= fir_en_s;
            for (int i = 1; i < FIR_LATENCY; i++) begin
                wr_pipe_r[i] <= wr_pipe_r[i-1];
            end

            // Write index restarts with every batch and steps on each write.
            if (state_r == ST_IDLE) begin
                wr_cnt_r <= ADDR_ZERO;
            end else if (wr_en_s) begin
                wr_cnt_r <= wr_cnt_r + ADDR_ONE;
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end

            case (state_r)
                ST_IDLE: begin
                    // Parameters are captured only here, so a mid-batch start has no effect.
                    if (bus.i_start) begin
                        len_r     <= bus.i_length;
                        rd_base_r <= bus.i_rd_base;
                        wr_base_r <= bus.i_wr_base;
                    end else begin
                        len_r     <= len_r;
                    end
                    rd_cnt_r  <= ADDR_ZERO;
                    rd_addr_r <= ADDR_ZERO;
                    rd_en_r   <= 1'b0;
                end
                ST_CLEAR: begin
                    // Present the first read as READ begins.
                    rd_cnt_r  <= ADDR_ZERO;
                    rd_addr_r <= rd_base_r;
                    rd_en_r   <= 1'b1;
                end
                ST_READ: begin
                    if (last_rd_s) begin
                        rd_addr_r <= ADDR_ZERO;
                        rd_en_r   <= 1'b0;
                    end else begin
                        rd_cnt_r  <= rd_cnt_r + ADDR_ONE;
                        rd_addr_r <= rd_addr_r + ADDR_ONE;
                        rd_en_r   <= 1'b1;
                    end
                end
                default: begin
                    rd_addr_r <= ADDR_ZERO;
                    rd_en_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy       = busy_r;
    assign bus.o_done       = done_r;
    assign bus.o_fir_reset  = i_reset | clear_r;
    assign bus.o_rd_en      = rd_en_r;
    assign bus.o_rd_addr    = rd_addr_r;
    assign bus.o_fir_en     = fir_en_s;
    assign bus.o_fir_signal = bus.i_rd_data;
    assign bus.o_wr_en      = wr_en_s;
    // Address is forced to zero outside write cycles so idle outputs stay quiet.
    assign bus.o_wr_addr    = wr_en_s ? (wr_base_r + wr_cnt_r) : ADDR_ZERO;
    assign bus.o_wr_data    = bus.i_fir_signal;

endmodule

// File: tb/tb_fir_bram_ctrl.sv
// Testbench for fir_bram_ctrl: BRAM and FIR behavioural models around the DUT,
// expected per-cycle outputs computed from the batch timeline and a direct
// convolution of the input region.
module tb_fir_bram_ctrl;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int LAT = 4;   // RD_LATENCY + FIR_LATENCY
    localparam int COEF [0:4] = '{1, 2, 3, 2, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_bram_ctrl_if #(.WW_ADDR(AW), .WW_DATA(DW)) bus ();

    fir_bram_ctrl #(.WW_ADDR(AW), .WW_DATA(DW), .RD_LATENCY(1), .FIR_LATENCY(3)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    logic [7:0] in_mem  [0:1023];
    logic [7:0] out_mem [0:1023];
    logic [7:0] rd_q;
    logic [7:0] hist    [0:3];
    logic [7:0] fpipe   [0:2];
    bit         fir_real;

    logic [33:0] cap_vec [0:63];
    logic [33:0] e_vec   [0:63];
    int          gold    [0:63];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Input BRAM with one-cycle read latency and output BRAM write port.
    always @(posedge clk) begin
        if (bus.o_rd_en) rd_q <= in_mem[bus.o_rd_addr];
        if (bus.o_wr_en) out_mem[bus.o_wr_addr] <= bus.o_wr_data;
    end
    assign bus.i_rd_data    = rd_q;
    assign bus.i_fir_signal = fpipe[2];

    function automatic logic [7:0] fir_step(input logic [7:0] x);
        int acc;
        acc = COEF[0]*int'(x) + COEF[1]*int'(hist[0]) + COEF[2]*int'(hist[1])
            + COEF[3]*int'(hist[2]) + COEF[4]*int'(hist[3]);
        return fir_real ? 8'(acc >> 2) : x;
    endfunction

    // FIR model: 5-tap history, result emerges three clocks after the enable cycle.
    always @(posedge clk) begin
        if (bus.o_fir_reset) begin
            for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
            for (int i = 0; i < 3; i++) fpipe[i] <= 8'h00;
        end else begin
            if (bus.o_fir_en) begin
                hist[0] <= bus.o_fir_signal;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                hist[3] <= hist[2];
            end
            fpipe[0] <= bus.o_fir_en ? fir_step(bus.o_fir_signal) : 8'h00;
            fpipe[1] <= fpipe[0];
            fpipe[2] <= fpipe[1];
        end
    end

    function automatic logic [33:0] sample_vec();
        return {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_fir_reset, bus.o_fir_en,
                bus.o_wr_en, bus.o_rd_addr, bus.o_wr_addr,
                (bus.o_wr_en ? bus.o_wr_data : 8'h00)};
    endfunction

    // Expected outputs for a single batch started (sampled) at cycle 0.
    task automatic build_expect(input int n, input logic [9:0] rdb, input logic [9:0] wrb);
        logic b, d, r, fr, fe, we;
        logic [9:0] ra, wa;
        logic [7:0] wd;
        for (int m = 0; m < n; m++) begin
            int acc = 0;
            for (int k = 0; k < 5; k++)
                if (m - k >= 0) acc += COEF[k] * int'(in_mem[10'(int'(rdb) + m - k)]);
            gold[m] = fir_real ? ((acc >> 2) & 255) : int'(in_mem[10'(int'(rdb) + m)]);
        end
        for (int c = 0; c < 64; c++) begin
            b  = (n == 0) ? (c == 1) : (c >= 1 && c <= n + 2 + LAT);
            d  = (n == 0) ? (c == 1) : (c == n + 2 + LAT);
            r  = (n > 0) && (c >= 2) && (c <= n + 1);
            fr = (n > 0) && (c == 1);
            fe = (n > 0) && (c >= 3) && (c <= n + 2);
            we = (n > 0) && (c >= 2 + LAT) && (c <= n + 1 + LAT);
            ra = r  ? 10'(int'(rdb) + c - 2) : 10'h000;
            wa = we ? 10'(int'(wrb) + c - 2 - LAT) : 10'h000;
            wd = we ? 8'(gold[c - 2 - LAT]) : 8'h00;
            e_vec[c] = {b, d, r, fr, fe, we, ra, wa, wd};
        end
    endtask

    // Drive one start at cycle 0 and capture outputs for cycles 0..ncyc.
    task automatic run_batch(input int n, input logic [9:0] rdb, input logic [9:0] wrb,
                             input bit hold, input int rst_at, input int ncyc);
        @(posedge clk); #1;
        bus.i_start   = 1'b1;
        bus.i_length  = 10'(n);
        bus.i_rd_base = rdb;
        bus.i_wr_base = wrb;
        #1 cap_vec[0] = sample_vec();
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (!hold) bus.i_start = 1'b0;
            rst = (c == rst_at);
            #1 cap_vec[c] = sample_vec();
        end
        bus.i_start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic fill(input logic [9:0] base, input int n);
        for (int i = 0; i < n; i++) in_mem[10'(int'(base) + i)] = 8'($urandom_range(255, 0));
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sample_vec() !== 34'h0_4000_0000)
            $display("FAIL reset_hold: got %h expected %h", sample_vec(), 34'h0_4000_0000);
        else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        n_checks++;
        if (sample_vec() !== 34'h0) $display("FAIL reset_release: got %h expected 0", sample_vec());
        else n_pass++;
        @(posedge clk); #2;
        n_checks++;
        if (sample_vec() !== 34'h0) $display("FAIL idle_after_reset: got %h expected 0", sample_vec());
        else n_pass++;
    endtask

    task automatic test_stub_basic();
        logic [7:0] want;
        fir_real = 1'b0;
        in_mem[10'h010] = 8'd11; in_mem[10'h011] = 8'd22;
        in_mem[10'h012] = 8'd33; in_mem[10'h013] = 8'd44;
        build_expect(4, 10'h010, 10'h200);
        run_batch(4, 10'h010, 10'h200, 1'b0, -1, 14);
        for (int c = 0; c <= 14; c++) begin
            n_checks++;
            if (cap_vec[c] !== e_vec[c])
                $display("FAIL stub_basic cycle %0d: got %h expected %h", c, cap_vec[c], e_vec[c]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            want = 8'(11 * (i + 1));
            n_checks++;
            if (out_mem[10'h200 + 10'(i)] !== want)
                $display("FAIL stub_mem[%0d]: got %0d expected %0d", i, out_mem[10'h200 + 10'(i)], want);
            else n_pass++;
        end
    endtask

    task automatic test_real_fir();
        fir_real = 1'b1;
        for (int i = 0; i < 16; i++) in_mem[10'h100 + 10'(i)] = 8'h00;
        in_mem[10'h100] = 8'h40;
        build_expect(16, 10'h100, 10'h300);
        run_batch(16, 10'h100, 10'h300, 1'b0, -1, 26);
        for (int c = 0; c <= 26; c++) begin
            n_checks++;
            if (cap_vec[c] !== e_vec[c])
                $display("FAIL real_fir cycle %0d: got %h expected %h", c, cap_vec[c], e_vec[c]);
            else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (int'(out_mem[10'h300 + 10'(i)]) !== gold[i])
                $display("FAIL impulse_resp[%0d]: got %0d expected %0d", i, out_mem[10'h300 + 10'(i)], gold[i]);
            else n_pass++;
        end
        n_checks++;
        if (out_mem[10'h302] !== 8'h30) $display("FAIL impulse_peak: got %h expected 30", out_mem[10'h302]);
        else n_pass++;
        fir_real = 1'b0;
    endtask

    task automatic test_zero_len();
        build_expect(0, 10'h123, 10'h321);
        run_batch(0, 10'h123, 10'h321, 1'b0, -1, 6);
        for (int c = 0; c <= 6; c++) begin
            n_checks++;
            if (cap_vec[c] !== e_vec[c])
                $display("FAIL zero_len cycle %0d: got %h expected %h", c, cap_vec[c], e_vec[c]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        fill(10'h3FE, 3);
        build_expect(3, 10'h3FE, 10'h3FF);
        run_batch(3, 10'h3FE, 10'h3FF, 1'b0, -1, 13);
        for (int c = 0; c <= 13; c++) begin
            n_checks++;
            if (cap_vec[c] !== e_vec[c])
                $display("FAIL wrap cycle %0d: got %h expected %h", c, cap_vec[c], e_vec[c]);
            else n_pass++;
        end
        n_checks++;
        if (cap_vec[4][27:18] !== 10'h000) $display("FAIL wrap_rd_addr: got %h expected 000", cap_vec[4][27:18]);
        else n_pass++;
        n_checks++;
        if (cap_vec[8][17:8] !== 10'h001) $display("FAIL wrap_wr_addr: got %h expected 001", cap_vec[8][17:8]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill(10'h050, 8);
        run_batch(8, 10'h050, 10'h250, 1'b0, 5, 16);
        n_checks++;
        if (cap_vec[5][30] !== 1'b1) $display("FAIL mid_reset_fir_clear: got %b expected 1", cap_vec[5][30]);
        else n_pass++;
        for (int c = 6; c <= 16; c++) begin
            n_checks++;
            if (cap_vec[c] !== 34'h0)
                $display("FAIL mid_reset_quiet cycle %0d: got %h expected 0", c, cap_vec[c]);
            else n_pass++;
        end
        fill(10'h060, 5);
        build_expect(5, 10'h060, 10'h260);
        run_batch(5, 10'h060, 10'h260, 1'b0, -1, 15);
        for (int c = 0; c <= 15; c++) begin
            n_checks++;
            if (cap_vec[c] !== e_vec[c])
                $display("FAIL after_reset cycle %0d: got %h expected %h", c, cap_vec[c], e_vec[c]);
            else n_pass++;
        end
    endtask

    task automatic test_start_held();
        int dones;
        bit idle_seen;
        fill(10'h080, 2);
        build_expect(2, 10'h080, 10'h280);
        run_batch(2, 10'h080, 10'h280, 1'b1, -1, 12);
        for (int c = 0; c <= 9; c++) begin
            n_checks++;
            if (cap_vec[c] !== e_vec[c])
                $display("FAIL start_held cycle %0d: got %h expected %h", c, cap_vec[c], e_vec[c]);
            else n_pass++;
        end
        dones = 0;
        for (int c = 0; c <= 12; c++) dones += int'(cap_vec[c][32]);
        n_checks++;
        if (dones !== 1) $display("FAIL held_done_count: got %0d expected 1", dones);
        else n_pass++;
        n_checks++;
        if (cap_vec[10][33] !== 1'b1 || cap_vec[10][30] !== 1'b1)
            $display("FAIL restart_cycle10: got busy=%b clr=%b expected 1 1", cap_vec[10][33], cap_vec[10][30]);
        else n_pass++;
        idle_seen = 1'b0;
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            @(posedge clk); #2;
            if (!bus.o_busy) idle_seen = 1'b1;
        end
        n_checks++;
        if (!idle_seen) $display("FAIL second_batch_finish: got busy expected idle within 40 cycles");
        else n_pass++;
    endtask

    task automatic test_random();
        int n, ncyc;
        logic [9:0] rdb, wrb;
        for (int it = 0; it < 6; it++) begin
            n    = int'($urandom_range(20, 1));
            rdb  = 10'($urandom_range(1023, 0));
            wrb  = rdb ^ 10'h200;
            fir_real = ($urandom_range(1, 0) == 1);
            ncyc = n + 10;
            fill(rdb, n);
            build_expect(n, rdb, wrb);
            run_batch(n, rdb, wrb, 1'b0, -1, ncyc);
            for (int c = 0; c <= ncyc; c++) begin
                n_checks++;
                if (cap_vec[c] !== e_vec[c])
                    $display("FAIL random%0d n=%0d cycle %0d: got %h expected %h", it, n, c, cap_vec[c], e_vec[c]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_start   = 1'b0;
        bus.i_length  = 10'h000;
        bus.i_rd_base = 10'h000;
        bus.i_wr_base = 10'h000;
        fir_real      = 1'b0;
        test_reset();
        test_stub_basic();
        test_real_fir();
        test_zero_len();
        test_wrap();
        test_reset_mid();
        test_start_held();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fir_bram_ctrl.md
# fir_bram_ctrl

Batch sequencer for the BRAM-backed FIR lab datapath. On a start command it clears the FIR history and streams `i_length` samples from an input BRAM region into the FIR, one per clock. It writes each filtered result to an output BRAM region, aligned to the BRAM read latency and the FIR pipeline latency. It sits between the BRAM ports and the FIR filter instance and reports busy/done to the top level.

## Interface
- `WW_ADDR`, 10: BRAM address width; also the width of the length, base and counter signals.
- `WW_DATA`, 8: sample width, both input and output.
- `RD_LATENCY`, 1: BRAM read latency in clocks. Must be ≥1.
- `FIR_LATENCY`, 3: clocks from a FIR input cycle with `i_en`=1 to its valid output.

Ports:
- `i_clock` in 1: single clock; all logic on its rising edge.
- `i_reset` in 1: reset is synchronous and active-high.
- `i_start` in 1: start request. Sampled only in IDLE.
- `i_length` in WW_ADDR: number of samples; 0 is legal.
- `i_rd_base` in WW_ADDR: first input BRAM address.
- `i_wr_base` in WW_ADDR: first output BRAM address.
- `o_busy` out 1: high while a batch is in progress.
- `o_done` out 1: one-cycle pulse at batch completion.
- `o_rd_en` out 1: input BRAM read enable.
- `o_rd_addr` out WW_ADDR: input BRAM read address.
- `i_rd_data` in WW_DATA: input BRAM read data, valid RD_LATENCY clocks after `o_rd_en`.
- `o_fir_reset` out 1: FIR synchronous clear.
- `o_fir_en` out 1: FIR shift enable.
- `o_fir_signal` out WW_DATA: FIR input sample.
- `i_fir_signal` in WW_DATA: FIR output sample.
- `o_wr_en` out 1: output BRAM write enable.
- `o_wr_addr` out WW_ADDR: output BRAM write address.
- `o_wr_data` out WW_DATA: output BRAM write data.

## Operation
- **States:** IDLE, CLEAR, READ, DRAIN, DONE. Encoding is free.
- **IDLE**
  - `i_start`=1 and `i_length`≠0: latch length and both base addresses, go to CLEAR.
  - `i_start`=1 and `i_length`=0: go to DONE. No reads, writes or FIR clear.
- **CLEAR:** exactly one cycle with `o_fir_reset`=1, then go to READ.
- **READ**
  - Each cycle: `o_rd_en`=1, `o_rd_addr` = rd_base + rd_cnt (mod 2^WW_ADDR), rd_cnt increments.
  - After the cycle with rd_cnt = length−1, go to DRAIN.
- **Read-valid pipeline:** a shift chain of depth RD_LATENCY carries `o_rd_en`.
  - `o_fir_en` is the chain output.
  - `o_fir_signal` = `i_rd_data` (wire).
- **Write-valid pipeline:** `o_fir_en` is delayed by FIR_LATENCY more stages to give `o_wr_en`.
  - `o_wr_addr` = wr_base + wr_cnt (mod 2^WW_ADDR).
  - `o_wr_data` = `i_fir_signal` (wire).
  - wr_cnt increments on each write.
- **DRAIN:** no reads. Go to DONE in the cycle after the write with wr_cnt = length−1.
- **DONE:** `o_done`=1 for one cycle, then go to IDLE.
- **`i_start` while not in IDLE:** ignored. The latched parameters do not change mid-batch.
- **Address wrap:** addresses wrap modulo 2^WW_ADDR. Overlapping read and write regions are not detected; that is the user's responsibility.
- **Reset in any state, including mid-batch**
  - Next state is IDLE; counters, both pipelines and all outputs are cleared.
  - No further `o_wr_en` pulses occur from the aborted batch.
  - `o_fir_reset`=1 during every cycle `i_reset`=1.

## Timing
- **Output values in reset/IDLE:**
  - `o_busy`, `o_done`, `o_rd_en`, `o_fir_en`, `o_wr_en`, `o_fir_reset` = 0 (except `o_fir_reset`=1 while `i_reset`=1).
  - `o_rd_addr`, `o_wr_addr` = 0.
- **Defaults below:** RD_LATENCY=1, FIR_LATENCY=3, start sampled at cycle 0, N≠0.
  - Cycle 1: CLEAR.
  - Cycles 2..N+1: reads.
  - Cycles 3..N+2: `o_fir_en` high.
  - Cycles 6..N+5: writes.
  - Cycle N+6: `o_done`.
- **General case:** first write at 2+RD_LATENCY+FIR_LATENCY; `o_done` at N+2+RD_LATENCY+FIR_LATENCY.
- **Busy window:** `o_busy`=1 from cycle 1 through the `o_done` cycle inclusive.
- **N=0:** `o_busy` and `o_done` both high at cycle 1.
- **Restart:** a new `i_start` is accepted no earlier than the first IDLE cycle after `o_done`.
- **Throughput:** `o_fir_en` and `o_wr_en` are each high N consecutive cycles, with no gaps.

## Test plan
- **Stub FIR (pure 3-cycle delay), N=4, rd_base=0x010, wr_base=0x200, BRAM[0x010..0x013] = 11,22,33,44** -> writes at cycles 6..9 to 0x200..0x203 with data 11,22,33,44; `o_done` at cycle 10; `o_busy` high cycles 1..10.
- **Real FIR, impulse 0x40 followed by zeros, N=16** -> the output region holds the filter impulse response, matching the golden model sample for sample; `o_fir_reset` pulses at cycle 1.
- **N=0** -> no `o_rd_en`, `o_wr_en` or `o_fir_reset`; `o_done` at cycle 1.
- **rd_base=0x3FE, wr_base=0x3FF, N=3** -> read addresses 0x3FE, 0x3FF, 0x000; write addresses 0x3FF, 0x000, 0x001.
- **`i_reset` asserted at cycle 5 of an N=8 batch** -> no `o_wr_en` from cycle 6 onward, all outputs at reset values, a following start runs a clean batch.
- **`i_start` held high for the whole of an N=2 batch** -> a single batch runs, `o_done` at cycle 8, and a second batch starts at cycle 9.
